ifetch_buf: RTL and testbench
=============================

IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction buffer entries; legal values are 2 and 4 only.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iaddr, output, 32, the fetch address driven to instruction memory.
REQ-006 SHALL have port idata, input, 32, instruction data, combinationally valid in the same cycle as iaddr.
REQ-007 SHALL have port out_valid, output, 1, meaning the buffer head holds a valid instruction.
REQ-008 SHALL have port out_ready, input, 1, meaning the downstream decode stage accepts the head.
REQ-009 SHALL have port out_instr, output, 32, the instruction word at the buffer head.
REQ-010 SHALL have port out_pc, output, 32, the address of out_instr.
REQ-011 SHALL have port redirect_valid, input, 1, meaning a branch/jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 32, the redirect target address.
REQ-013 SHALL have port misalign_err, output, 1, the misaligned-redirect error pulse.

Function
REQ-014 SHALL drive iaddr directly from the internal pc register, with no combinational path from any input.
REQ-015 SHALL push the entry {pc, idata} and update pc <= pc + 4 on a cycle where push is allowed; push is allowed when no redirect, not halted, and (count < DEPTH or a pop occurs that cycle).
REQ-016 SHALL pop the head when out_valid && out_ready && !redirect_valid.
REQ-017 SHALL allow push and pop in the same cycle at any fill level, including full; count is then unchanged.
REQ-018 SHALL drive out_valid = (count != 0), and SHALL drive out_instr/out_pc from the head entry (0 when empty).
REQ-019 SHALL hold out_instr and out_pc stable while out_valid && !out_ready && !redirect_valid.
REQ-020 SHALL take priority for redirect_valid over push and pop: flush the buffer (count <= 0), load pc from redirect_pc, and neither push nor pop that cycle.
REQ-021 SHALL drive iaddr = redirect target in the cycle after a redirect, with the first redirected instruction out_valid two cycles after the redirect edge.
REQ-022 SHALL wrap pc modulo 2^32: pc 32'hFFFF_FFFC + 4 becomes 32'h0000_0000.
REQ-023 SHALL implement the buffer as a circular FIFO with read/write pointers wrapping modulo DEPTH.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set pc <= RESET_PC, count and pointers <= 0, halted <= 0, and misalign_err <= 0, taking priority over redirect, push and pop.
REQ-025 SHALL, during reset and in the first cycle after it, drive out_valid = 0, out_instr = 0, out_pc = 0, and iaddr = RESET_PC.
REQ-026 SHALL, with reset asserted mid-operation, discard all buffered entries; the first instruction after release is fetched from RESET_PC.

Configuration
REQ-027 SHALL, with macro IFETCH_MISALIGN_TRAP_EN defined and redirect_pc[1:0] != 0 at a redirect: flush, load pc <= redirect_pc, set halted (no pushes), and pulse misalign_err for exactly one cycle after the edge.
REQ-028 SHALL, with IFETCH_MISALIGN_TRAP_EN defined, clear halted only on an aligned redirect or reset.
REQ-029 SHALL, with IFETCH_MISALIGN_TRAP_EN undefined, load pc <= {redirect_pc[31:2], 2'b00} silently, tie misalign_err to 0, and never set halted.

Verification
REQ-030 SHALL cover reset release with RESET_PC=0, imem word[i]=i, and out_ready=1 -> out_valid rises one cycle after release; out_pc sequence 0,4,8,...; out_instr 0,1,2,...
REQ-031 SHALL cover out_ready held 0 for 10 cycles with DEPTH=2 -> count saturates at 2; iaddr frozen at 8; out_pc holds 0; on release, no instruction lost or duplicated.
REQ-032 SHALL cover redirect_pc=32'h100 asserted while full with out_ready=1 -> no pop that cycle; out_valid=0 next cycle; next out_pc=32'h100.
REQ-033 SHALL cover redirect_pc=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 SHALL cover redirect_pc=32'h102 with IFETCH_MISALIGN_TRAP_EN defined -> misalign_err=1 for one cycle; out_valid stays 0 until redirect 32'h200; then out_pc=32'h200.
REQ-035 SHALL cover redirect_pc=32'h102 with IFETCH_MISALIGN_TRAP_EN undefined -> misalign_err=0; first out_pc=32'h100.

Source files
------------

// File: rtl/ifetch_buf.sv
// Instruction fetch unit: a PC register feeding instruction memory and a small circular
// buffer of {pc, instr} entries toward decode. Optional macro: IFETCH_MISALIGN_TRAP_EN.
module ifetch_buf #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] iaddr,
   input  logic [31:0] idata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [31:0]   pc;
   logic [PW:0]   count;
   logic [PW-1:0] wrptr;
   logic [PW-1:0] rdptr;
   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];
   logic          halted;
   logic          push;
   logic          pop;
   logic [31:0]   redirect_target;

   assign iaddr     = pc;
   assign out_valid = (count != '0);
   assign out_instr = out_valid ? fifo_instr[rdptr] : 32'h0;
   assign out_pc    = out_valid ? fifo_pc[rdptr] : 32'h0;

   // Redirect outranks everything; a pop makes room for a push even when full.
   assign pop  = out_valid && out_ready && !redirect_valid;
   assign push = !redirect_valid && !halted && ((count < FULL) || pop);

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic redirect_misaligned;

   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
   assign redirect_target     = redirect_pc;

   // A misaligned redirect parks the fetcher until an aligned redirect arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted       <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redirect_valid && redirect_misaligned;
         if (redirect_valid) begin
            halted <= redirect_misaligned;
         end
      end
   end
`else
   logic unused_low_bits;

   assign unused_low_bits = ^redirect_pc[1:0];
   assign redirect_target = {redirect_pc[31:2], 2'b00};
   assign halted          = 1'b0;
   assign misalign_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_PC;
         count <= '0;
         wrptr <= '0;
         rdptr <= '0;
      end else if (redirect_valid) begin
         pc    <= redirect_target;
         count <= '0;
         wrptr <= '0;
         rdptr <= '0;
      end else begin
         if (push) begin
            pc    <= pc + 32'd4;
            wrptr <= wrptr + PW'(1);
         end
         if (pop) begin
            rdptr <= rdptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + (PW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (PW+1)'(1);
         end
      end
   end

   // Entry storage needs no reset; count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         fifo_pc[wrptr]    <= pc;
         fifo_instr[wrptr] <= idata;
      end
   end

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed self-checking bench for ifetch_buf; instruction memory returns word index (addr >> 2).
module tb_ifetch_buf;

   logic        clk;
   logic        reset;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   int nasserts = 0;
   int nfails   = 0;

   ifetch_buf #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk),
      .reset(reset),
      .iaddr(iaddr),
      .idata(idata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .misalign_err(misalign_err)
   );

   assign idata = iaddr >> 2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then settle just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc);
      reset          = rst;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nasserts++;
      assert (obs === exp) else begin
         nfails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] wrap_pc [3];
      logic [31:0] wrap_ia [3];
      wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      wrap_ia = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_instr", out_instr, 32'h0);
      checkOutput("rst_pc", out_pc, 32'h0);
      checkOutput("rst_iaddr", iaddr, 32'h0);
      checkOutput("rst_err", 32'(misalign_err), 32'h0);

      // Streaming from reset with decode always ready.
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkOutput("stream_valid", 32'(out_valid), 32'h1);
         checkOutput("stream_pc", out_pc, 32'(4 * (k - 1)));
         checkOutput("stream_instr", out_instr, 32'(k - 1));
         checkOutput("stream_iaddr", iaddr, 32'(4 * k));
      end

      // Mid-operation reset drops buffered entries.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("midrst_valid", 32'(out_valid), 32'h0);
      checkOutput("midrst_iaddr", iaddr, 32'h0);

      // Decode stalled for 10 cycles: buffer fills, fetch freezes.
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         checkOutput("stall_valid", 32'(out_valid), 32'h1);
         checkOutput("stall_pc", out_pc, 32'h0);
         checkOutput("stall_instr", out_instr, 32'h0);
         checkOutput("stall_iaddr", iaddr, (k >= 2) ? 32'h8 : 32'(4 * k));
      end

      // Release: sequence continues with no gap or repeat.
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkOutput("release_pc", out_pc, 32'(4 * k));
         checkOutput("release_instr", out_instr, 32'(k));
      end

      // Redirect while full and ready: flush instead of pop.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
      checkOutput("redir_valid", 32'(out_valid), 32'h0);
      checkOutput("redir_iaddr", iaddr, 32'h100);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("redir_valid2", 32'(out_valid), 32'h1);
      checkOutput("redir_pc", out_pc, 32'h100);
      checkOutput("redir_instr", out_instr, 32'h40);

      // PC wraps past the top of the address space.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      checkOutput("wrap_valid0", 32'(out_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkOutput("wrap_valid", 32'(out_valid), 32'h1);
         checkOutput("wrap_pc", out_pc, wrap_pc[k]);
         checkOutput("wrap_instr", out_instr, wrap_pc[k] >> 2);
         checkOutput("wrap_iaddr", iaddr, wrap_ia[k]);
      end

      // Misaligned redirect target.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
      checkOutput("mis_err", 32'(misalign_err), 32'h1);
      checkOutput("mis_iaddr", iaddr, 32'h102);
      checkOutput("mis_valid", 32'(out_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkOutput("halt_err", 32'(misalign_err), 32'h0);
         checkOutput("halt_valid", 32'(out_valid), 32'h0);
         checkOutput("halt_iaddr", iaddr, 32'h102);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
      checkOutput("unhalt_valid", 32'(out_valid), 32'h0);
      checkOutput("unhalt_err", 32'(misalign_err), 32'h0);
      checkOutput("unhalt_iaddr", iaddr, 32'h200);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("unhalt_valid2", 32'(out_valid), 32'h1);
      checkOutput("unhalt_pc", out_pc, 32'h200);
`else
      checkOutput("mis_err", 32'(misalign_err), 32'h0);
      checkOutput("mis_iaddr", iaddr, 32'h100);
      checkOutput("mis_valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("mis_valid2", 32'(out_valid), 32'h1);
      checkOutput("mis_pc", out_pc, 32'h100);
      checkOutput("mis_instr", out_instr, 32'h40);
      checkOutput("mis_err2", 32'(misalign_err), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
      $finish;
   end

endmodule
